// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and helpers for the chunked pipelined adder.
//   DEFAULT_WIDTH : default operand/sum width in bits
//   DEFAULT_CHUNK : default number of bits added per pipeline stage
//   stage_count() : pipeline depth for a given width and chunk size
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  // Returns WIDTH/CHUNK. Degenerate arguments return 1 so that array
  // declarations stay legal long enough for the parameter check in the
  // top module to report a readable elaboration error.
  function automatic int stage_count(input int width, input int chunk);
    if (chunk <= 0 || width < chunk) begin
      return 1;
    end
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Purely combinational CHUNK-bit adder slice.
//   i_a, i_b : CHUNK-bit operand slices
//   i_cin    : carry into bit 0 of the slice
//   o_sum    : CHUNK-bit sum slice
//   o_cout   : carry out of the slice MSB
//   o_c_msb  : carry into the slice MSB (used for two's-complement overflow)
// -----------------------------------------------------------------------------
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum   = w_full[CHUNK-1:0];
  assign o_cout  = w_full[CHUNK];
  // The sum bit is a ^ b ^ carry_in at every position, so the carry into
  // the MSB falls out of the MSB sum bit without a second adder; this also
  // holds for CHUNK = 1, where it reduces to i_cin.
  assign o_c_msb = o_sum[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder split into STAGES = WIDTH/CHUNK register stages. Stage k
// adds operand bits [k*CHUNK +: CHUNK] with the carry registered by stage
// k-1 (stage 0 uses cin). Unconsumed operand bits travel with each stage and
// finished sum chunks are carried forward unchanged. One global advance
// signal stalls the whole pipeline under output backpressure.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset (clears valid bits and outputs)
//   in_valid  : a, b, cin valid this cycle
//   in_ready  : operands accepted this cycle (= !out_valid || out_ready)
//   a, b      : WIDTH-bit operands
//   cin       : carry into bit 0
//   out_valid : sum, cout, ovf hold a result
//   out_ready : consumer takes the result this cycle
//   sum       : (a + b + cin) mod 2^WIDTH
//   cout      : carry out of bit WIDTH-1
//   ovf       : two's-complement overflow
// -----------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Per-stage state. Only the valid bits carry a reset; operands, partial
  // sums and carries are don't-care whenever their valid bit is low.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_cy  [STAGES];

  // Output registers, reset so the result ports read zero after reset.
  logic [WIDTH-1:0] r_sum_o;
  logic             r_cout_o;
  logic             r_ovf_o;

  logic w_adv;

  // Whole pipeline moves together; the output slot frees up either because
  // it is empty or because the consumer is taking it this cycle.
  assign w_adv     = !r_vld[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum_o;
  assign cout      = r_cout_o;
  assign ovf       = r_ovf_o;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a_src;
    logic [WIDTH-1:0] w_b_src;
    logic [WIDTH-1:0] w_sum_src;
    logic [WIDTH-1:0] w_sum_nx;
    logic             w_cin_src;
    logic             w_vld_src;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;

    // ---- stage k input: external operands for k = 0, else stage k-1 ----
    if (k == 0) begin : g_first
      assign w_a_src   = a;
      assign w_b_src   = b;
      assign w_sum_src = '0;
      assign w_cin_src = cin;
      assign w_vld_src = in_valid;
    end else begin : g_next
      assign w_a_src   = r_a[k-1];
      assign w_b_src   = r_b[k-1];
      assign w_sum_src = r_sum[k-1];
      assign w_cin_src = r_cy[k-1];
      assign w_vld_src = r_vld[k-1];
    end

    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .i_a    (w_a_src[k*CHUNK +: CHUNK]),
      .i_b    (w_b_src[k*CHUNK +: CHUNK]),
      .i_cin  (w_cin_src),
      .o_sum  (w_s),
      .o_cout (w_co),
      .o_c_msb(w_c_msb)
    );

    // Lower chunks pass through untouched; this stage fills in chunk k.
    always_comb begin
      w_sum_nx                    = w_sum_src;
      w_sum_nx[k*CHUNK +: CHUNK]  = w_s;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld[k] <= 1'b0;
      end else if (w_adv) begin
        r_vld[k] <= w_vld_src;
      end
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_a[k]   <= w_a_src;
        r_b[k]   <= w_b_src;
        r_sum[k] <= w_sum_nx;
        r_cy[k]  <= w_co;
      end
    end

    // The final stage also loads the reset-able output registers. Loading
    // only on a valid result keeps bubbles from disturbing the last value.
    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum_o  <= '0;
          r_cout_o <= 1'b0;
          r_ovf_o  <= 1'b0;
        end else if (w_adv && w_vld_src) begin
          r_sum_o  <= w_sum_nx;
          r_cout_o <= w_co;
          r_ovf_o  <= w_co ^ w_c_msb;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic clk;

  // 32-bit / 8-bit-chunk instance
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  // 4-bit / 1-bit-chunk instance
  logic        v4_rst;
  logic        v4_in_valid;
  logic        v4_in_ready;
  logic [3:0]  v4_a;
  logic [3:0]  v4_b;
  logic        v4_cin;
  logic        v4_out_valid;
  logic        v4_out_ready;
  logic [3:0]  v4_sum;
  logic        v4_cout;
  logic        v4_ovf;

  int n_vec;
  int n_err;

  pipelined_adder #(
    .WIDTH(32),
    .CHUNK(8)
  ) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  pipelined_adder #(
    .WIDTH(4),
    .CHUNK(1)
  ) u_dut4 (
    .clk      (clk),
    .rst      (v4_rst),
    .in_valid (v4_in_valid),
    .in_ready (v4_in_ready),
    .a        (v4_a),
    .b        (v4_b),
    .cin      (v4_cin),
    .out_valid(v4_out_valid),
    .out_ready(v4_out_ready),
    .sum      (v4_sum),
    .cout     (v4_cout),
    .ovf      (v4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation through the 32-bit pipeline with out_ready held high.
  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] es, input logic ec, input logic eo);
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    tick();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check_val({tag, "_early"}, 64'(out_valid), 64'(0));
    tick();
    check_val({tag, "_vld"},  64'(out_valid), 64'(1));
    check_val({tag, "_sum"},  64'(sum),       64'(es));
    check_val({tag, "_cout"}, 64'(cout),      64'(ec));
    check_val({tag, "_ovf"},  64'(ovf),       64'(eo));
    tick();
    check_val({tag, "_drain"}, 64'(out_valid), 64'(0));
  endtask

  logic [5:0] exp_q[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    v4_rst = 1'b1; v4_in_valid = 1'b0; v4_a = '0; v4_b = '0; v4_cin = 1'b0; v4_out_ready = 1'b1;

    // ---- reset state ----
    tick();
    tick();
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_sum",       64'(sum),       64'(0));
    check_val("rst_cout",      64'(cout),      64'(0));
    check_val("rst_ovf",       64'(ovf),       64'(0));
    check_val("rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1'b0;
    v4_rst = 1'b0;

    // ---- directed single operations ----
    run_one("all_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_one("pos_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("neg_ovf",      32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_one("chunk_carry",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_one("mixed",        32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    run_one("minus1_x2",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // ---- back-to-back throughput ----
    in_valid = 1'b1; a = 32'd1; b = 32'd2;
    tick();
    a = 32'd3; b = 32'd4;
    tick();
    a = 32'd5; b = 32'd6;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    check_val("b2b_early", 64'(out_valid), 64'(0));
    tick();
    check_val("b2b_vld0", 64'(out_valid), 64'(1));
    check_val("b2b_sum0", 64'(sum), 64'(3));
    tick();
    check_val("b2b_vld1", 64'(out_valid), 64'(1));
    check_val("b2b_sum1", 64'(sum), 64'(7));
    tick();
    check_val("b2b_vld2", 64'(out_valid), 64'(1));
    check_val("b2b_sum2", 64'(sum), 64'(11));
    tick();
    check_val("b2b_drain", 64'(out_valid), 64'(0));

    // ---- backpressure: 4 in flight, consumer stalled 6 cycles ----
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; a = 32'(i * 10); b = 32'(i);
      tick();
    end
    // Offer a stray operand during the stall; it must not be taken.
    a = 32'd999; b = 32'd999;
    for (int i = 0; i < 6; i++) begin
      check_val("bp_in_ready", 64'(in_ready),  64'(0));
      check_val("bp_hold_vld", 64'(out_valid), 64'(1));
      check_val("bp_hold_sum", 64'(sum),       64'(11));
      tick();
    end
    in_valid = 1'b0; a = '0; b = '0;
    out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 64'(in_ready), 64'(1));
    check_val("bp_res0", 64'(sum), 64'(11));
    tick();
    check_val("bp_vld1", 64'(out_valid), 64'(1));
    check_val("bp_res1", 64'(sum), 64'(22));
    tick();
    check_val("bp_vld2", 64'(out_valid), 64'(1));
    check_val("bp_res2", 64'(sum), 64'(33));
    tick();
    check_val("bp_vld3", 64'(out_valid), 64'(1));
    check_val("bp_res3", 64'(sum), 64'(44));
    tick();
    check_val("bp_no_extra", 64'(out_valid), 64'(0));

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h100 + 32'(i); b = 32'h1;
      tick();
    end
    in_valid = 1'b0; a = '0; b = '0;
    tick();
    check_val("mid_pre_vld", 64'(out_valid), 64'(1));
    check_val("mid_pre_sum", 64'(sum), 64'(32'h101));
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_vld", 64'(out_valid), 64'(0));
    check_val("mid_rst_sum", 64'(sum), 64'(0));
    check_val("mid_rst_rdy", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (out_valid) stale++;
      end
      check_val("mid_no_stale", 64'(stale), 64'(0));
    end
    run_one("post_rst", 32'h0000_ABCD, 32'h0000_1111, 1'b0, 32'h0000_BCDE, 1'b0, 1'b0);

    // ---- exhaustive 4-bit sweep with random backpressure ----
    begin
      int idx;
      int got;
      int cyc;
      logic [4:0] full;
      logic [5:0] expv;
      logic [5:0] head;
      idx = 0;
      got = 0;
      cyc = 0;
      while (got < 512 && cyc < 6000) begin
        v4_out_ready = ($urandom_range(0, 3) != 0);
        v4_in_valid  = (idx < 512);
        v4_a   = 4'(idx);
        v4_b   = 4'(idx >> 4);
        v4_cin = 1'((idx >> 8) & 1);
        #1;
        if (v4_out_valid && v4_out_ready) begin
          head = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3F;
          check_val("sweep4", 64'({v4_ovf, v4_cout, v4_sum}), 64'(head));
          got++;
        end
        if (v4_in_valid && v4_in_ready) begin
          full = {1'b0, v4_a} + {1'b0, v4_b} + {4'b0, v4_cin};
          expv = {(v4_a[3] == v4_b[3]) && (full[3] != v4_a[3]), full};
          exp_q.push_back(expv);
          idx++;
        end
        tick();
        cyc++;
      end
      v4_in_valid = 1'b0;
      check_val("sweep4_count", 64'(got), 64'(512));
      check_val("sweep4_queue", 64'(exp_q.size()), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
